gal_fuse_loader: RTL and testbench

- Upstream configuration stage for the GAL_SOP product-term array.
- Accepts a serial JEDEC-style fuse stream and accumulates it in a shadow register.
- Verifies the 16-bit JEDEC fuse checksum.
- Commits the fuse image to a TABLE output only on a checksum match; the output drives the TABLE bit layout of GAL_SOP directly.

---
 rtl/gal_fuse_pkg.sv | 19 +
 rtl/gal_fuse_checksum.sv | 46 ++++
 rtl/gal_fuse_loader.sv | 121 ++++++++++++
 tb/tb_gal_fuse_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gal_fuse_pkg.sv
// Shared types, widths and helpers for the GAL_SOP fuse loader.
package gal_fuse_pkg;

   localparam int unsigned CHK_W  = 16;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCheck,
      StDone,
      StError
   } state_e;

   function automatic int unsigned nfuse(input int unsigned width, input int unsigned depth);
      return 2 * width * depth;
   endfunction

endpackage

// File: rtl/gal_fuse_checksum.sv
// JEDEC fuse checksum: packs accepted fuses LSB-first into bytes and sums the bytes mod 2^16.
module gal_fuse_checksum
   import gal_fuse_pkg::*;
(
   input  logic             C,
   input  logic             R,
   input  logic             clr,
   input  logic             accept,
   input  logic             bit_in,
   input  logic             flush,
   output logic [CHK_W-1:0] sum
);

   localparam int unsigned POS_W = $clog2(BYTE_W);

   logic [BYTE_W-1:0] acc_q;
   logic [BYTE_W-1:0] byte_nxt;
   logic [POS_W-1:0]  pos_q;
   logic              byte_full;

   always_comb begin
      byte_nxt        = acc_q;
      byte_nxt[pos_q] = bit_in;
   end

   // flush closes a zero-padded partial byte; a full byte is never added twice
   assign byte_full = (pos_q == POS_W'(BYTE_W - 1)) || flush;

   always_ff @(posedge C) begin
      if (R || clr) begin
         acc_q <= '0;
         pos_q <= '0;
         sum   <= '0;
      end else if (accept) begin
         if (byte_full) begin
            sum   <= sum + {{(CHK_W - BYTE_W){1'b0}}, byte_nxt};
            acc_q <= '0;
            pos_q <= '0;
         end else begin
            acc_q <= byte_nxt;
            pos_q <= pos_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/gal_fuse_loader.sv
// Serial fuse loader for GAL_SOP: shadows the stream, verifies the checksum, commits on match.
// Optional write-lock on committed images is built when GAL_FUSE_SECURITY_EN is defined.
module gal_fuse_loader
   import gal_fuse_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned NFUSE = nfuse(WIDTH, DEPTH)
) (
   input  logic             C,
   input  logic             R,
   input  logic             start,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   input  logic [CHK_W-1:0] chk_in,
   input  logic             chk_valid,
`ifdef GAL_FUSE_SECURITY_EN
   input  logic             sec_in,
`endif
   output logic [NFUSE-1:0] table_out,
   output logic             loaded,
   output logic             chk_err,
   output logic             busy
);

   localparam int unsigned CNT_W = (NFUSE > 1) ? $clog2(NFUSE) : 1;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [NFUSE-1:0] shadow_q;
   logic [CHK_W-1:0] sum;
   logic             start_ok;
   logic             idle_like;
   logic             accept;
   logic             last_bit;
   logic             clr;

`ifdef GAL_FUSE_SECURITY_EN
   logic lock_q;
   assign start_ok = start && !lock_q;
`else
   assign start_ok = start;
`endif

   assign idle_like = (state_q == StIdle) || (state_q == StDone) || (state_q == StError);
   assign clr       = idle_like && start_ok;
   assign accept    = bit_valid && bit_ready;
   assign last_bit  = (cnt_q == CNT_W'(NFUSE - 1));

   gal_fuse_checksum u_checksum (
      .C      (C),
      .R      (R),
      .clr    (clr),
      .accept (accept),
      .bit_in (bit_in),
      .flush  (accept && last_bit),
      .sum    (sum)
   );

   always_ff @(posedge C) begin
      if (R) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         shadow_q  <= '0;
         table_out <= '1;
         loaded    <= 1'b0;
         chk_err   <= 1'b0;
         busy      <= 1'b0;
         bit_ready <= 1'b0;
`ifdef GAL_FUSE_SECURITY_EN
         lock_q    <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle, StDone, StError: begin
               if (start_ok) begin
                  state_q   <= StLoad;
                  cnt_q     <= '0;
                  shadow_q  <= '0;
                  chk_err   <= 1'b0;
                  busy      <= 1'b1;
                  bit_ready <= 1'b1;
               end
            end
            StLoad: begin
               if (accept) begin
                  shadow_q[cnt_q] <= bit_in;
                  cnt_q           <= cnt_q + 1'b1;
                  if (last_bit) begin
                     state_q   <= StCheck;
                     bit_ready <= 1'b0;
                  end
               end
            end
            StCheck: begin
               if (chk_valid) begin
                  busy <= 1'b0;
                  if (chk_in == sum) begin
                     table_out <= shadow_q;
                     loaded    <= 1'b1;
                     state_q   <= StDone;
`ifdef GAL_FUSE_SECURITY_EN
                     if (sec_in) begin
                        lock_q <= 1'b1;
                     end
`endif
                  end else begin
                     chk_err <= 1'b1;
                     state_q <= StError;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gal_fuse_loader.sv
// Scoreboard bench for gal_fuse_loader: three instances (8, 6 and 128 fuses) on one clock.
module tb_gal_fuse_loader;

   typedef struct {
      logic [127:0] tbl;
      logic         ld;
      logic         er;
   } exp_t;

   localparam logic [127:0] ONES = {128{1'b1}};
   localparam logic [127:0] PAT  = 128'h0F0E0D0C0B0A09080706050403020100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0]  sel;
   logic        rst_all, drv_rst, drv_start, drv_bit, drv_valid, drv_chk_valid;
   logic [15:0] drv_chk;
`ifdef GAL_FUSE_SECURITY_EN
   logic        drv_sec;
`endif

   logic [2:0]   r_v, start_v, valid_v, cv_v;
   logic [2:0]   ready_v, busy_v, loaded_v, err_v;
   logic [7:0]   t0;
   logic [5:0]   t1;
   logic [127:0] t2;
   logic         sel_busy, sel_ready;

   exp_t q0[$], q1[$], q2[$];

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         r_v[k]     = rst_all | (drv_rst & (sel == 2'(k)));
         start_v[k] = drv_start & (sel == 2'(k));
         valid_v[k] = drv_valid & (sel == 2'(k));
         cv_v[k]    = drv_chk_valid & (sel == 2'(k));
      end
      sel_busy  = busy_v[sel];
      sel_ready = ready_v[sel];
   end

   gal_fuse_loader #(.WIDTH(2), .DEPTH(2)) u_d0 (
      .C(clk), .R(r_v[0]), .start(start_v[0]), .bit_in(drv_bit), .bit_valid(valid_v[0]),
      .bit_ready(ready_v[0]), .chk_in(drv_chk), .chk_valid(cv_v[0]),
`ifdef GAL_FUSE_SECURITY_EN
      .sec_in(drv_sec),
`endif
      .table_out(t0), .loaded(loaded_v[0]), .chk_err(err_v[0]), .busy(busy_v[0])
   );

   gal_fuse_loader #(.WIDTH(3), .DEPTH(1)) u_d1 (
      .C(clk), .R(r_v[1]), .start(start_v[1]), .bit_in(drv_bit), .bit_valid(valid_v[1]),
      .bit_ready(ready_v[1]), .chk_in(drv_chk), .chk_valid(cv_v[1]),
`ifdef GAL_FUSE_SECURITY_EN
      .sec_in(1'b0),
`endif
      .table_out(t1), .loaded(loaded_v[1]), .chk_err(err_v[1]), .busy(busy_v[1])
   );

   gal_fuse_loader u_d2 (
      .C(clk), .R(r_v[2]), .start(start_v[2]), .bit_in(drv_bit), .bit_valid(valid_v[2]),
      .bit_ready(ready_v[2]), .chk_in(drv_chk), .chk_valid(cv_v[2]),
`ifdef GAL_FUSE_SECURITY_EN
      .sec_in(1'b0),
`endif
      .table_out(t2), .loaded(loaded_v[2]), .chk_err(err_v[2]), .busy(busy_v[2])
   );

   function automatic void check(input string name, input logic [127:0] act,
                                 input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic exp_t mk(input logic [127:0] t, input logic l, input logic r);
      exp_t e;
      e.tbl = t;
      e.ld  = l;
      e.er  = r;
      return e;
   endfunction

   function automatic void push(input logic [1:0] id, input exp_t e);
      case (id)
         2'd0:    q0.push_back(e);
         2'd1:    q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endfunction

   function automatic void mon_pop(input int id, input logic [127:0] tbl, input logic ld,
                                   input logic er, input logic rdy);
      exp_t e;
      int   sz;
      sz = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard d%0d: got result table %h, expected no result", id, tbl);
         return;
      end
      case (id)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
      check($sformatf("d%0d table_out", id), tbl, e.tbl);
      check($sformatf("d%0d loaded", id), {127'b0, ld}, {127'b0, e.ld});
      check($sformatf("d%0d chk_err", id), {127'b0, er}, {127'b0, e.er});
      check($sformatf("d%0d bit_ready idle", id), {127'b0, rdy}, 128'b0);
   endfunction

   // Monitor: a result is presented whenever busy falls.
   logic [2:0] busy_d = '0;
   always @(negedge clk) begin
      if (busy_d[0] && !busy_v[0]) mon_pop(0, {120'b0, t0}, loaded_v[0], err_v[0], ready_v[0]);
      if (busy_d[1] && !busy_v[1]) mon_pop(1, {122'b0, t1}, loaded_v[1], err_v[1], ready_v[1]);
      if (busy_d[2] && !busy_v[2]) mon_pop(2, t2, loaded_v[2], err_v[2], ready_v[2]);
      busy_d <= busy_v;
   end

   task automatic wait_idle();
      int k = 0;
      while (sel_busy !== 1'b0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("returned idle", {127'b0, sel_busy}, 128'b0);
   endtask

   task automatic do_load(input logic [1:0] id, input logic [127:0] bits, input int n,
                          input bit gap, input int mid_start, input logic [15:0] chk_val,
                          input int wait_cyc, input bit early, input exp_t e);
      sel       = id;
      drv_start = 1'b1;
      @(negedge clk);
      drv_start = 1'b0;
      check("busy after start", {127'b0, sel_busy}, 128'b1);
      for (int i = 0; i < n; i++) begin
         drv_bit   = bits[i];
         drv_valid = 1'b1;
         drv_start = (i == mid_start);
         if (i == n - 1) begin
            check("ready before last", {127'b0, sel_ready}, 128'b1);
            if (early) begin
               drv_chk       = chk_val;
               drv_chk_valid = 1'b1;
               push(id, e);
            end
         end
         @(negedge clk);
         drv_start = 1'b0;
         if (i == n - 1) begin
            check("ready after last", {127'b0, sel_ready}, 128'b0);
            check("busy after last", {127'b0, sel_busy}, 128'b1);
         end
         if (gap) begin
            drv_valid = 1'b0;
            @(negedge clk);
         end
      end
      drv_valid = 1'b0;
      if (early) begin
         @(negedge clk);
      end else begin
         for (int w = 0; w < wait_cyc; w++) begin
            drv_start = (w == 0);
            @(negedge clk);
            drv_start = 1'b0;
         end
         drv_chk       = chk_val;
         drv_chk_valid = 1'b1;
         push(id, e);
         @(negedge clk);
      end
      drv_chk_valid = 1'b0;
      wait_idle();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sel           = 2'd0;
      rst_all       = 1'b1;
      drv_rst       = 1'b0;
      drv_start     = 1'b0;
      drv_bit       = 1'b0;
      drv_valid     = 1'b0;
      drv_chk_valid = 1'b0;
      drv_chk       = 16'h0;
`ifdef GAL_FUSE_SECURITY_EN
      drv_sec       = 1'b0;
`endif
      repeat (3) @(negedge clk);
      rst_all = 1'b0;

      check("reset d0 table", {120'b0, t0}, 128'hFF);
      check("reset d1 table", {122'b0, t1}, 128'h3F);
      check("reset d2 table", t2, ONES);
      check("reset loaded", {125'b0, loaded_v}, 128'b0);
      check("reset chk_err", {125'b0, err_v}, 128'b0);
      check("reset busy", {125'b0, busy_v}, 128'b0);
      check("reset bit_ready", {125'b0, ready_v}, 128'b0);

      // 8 fuses: bad checksum from reset, good commit, then a failure keeps the image
      do_load(2'd0, 128'h5A, 8, 1'b0, -1, 16'h005B, 0, 1'b0, mk(128'hFF, 1'b0, 1'b1));
      do_load(2'd0, 128'h5A, 8, 1'b0, -1, 16'h005A, 3, 1'b0, mk(128'h5A, 1'b1, 1'b0));
      do_load(2'd0, 128'h3C, 8, 1'b1, -1, 16'h0000, 0, 1'b0, mk(128'h5A, 1'b1, 1'b1));

      // 6 fuses: partial byte, chk_valid already high on the last bit
      do_load(2'd1, 128'h3F, 6, 1'b0, -1, 16'h003F, 0, 1'b1, mk(128'h3F, 1'b1, 1'b0));

      // 128 fuses: bit_valid toggling, start mid-load ignored
      do_load(2'd2, ONES, 128, 1'b1, 50, 16'h0FF0, 0, 1'b0, mk(ONES, 1'b1, 1'b0));
      do_load(2'd2, PAT, 128, 1'b0, -1, 16'h0078, 0, 1'b0, mk(PAT, 1'b1, 1'b0));

      // Reset after 40 of 128 bits discards the committed image
      sel       = 2'd2;
      drv_start = 1'b1;
      @(negedge clk);
      drv_start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         drv_bit   = PAT[i];
         drv_valid = 1'b1;
         @(negedge clk);
      end
      drv_valid = 1'b0;
      push(2'd2, mk(ONES, 1'b0, 1'b0));
      drv_rst = 1'b1;
      @(negedge clk);
      drv_rst = 1'b0;
      check("midreset busy", {127'b0, busy_v[2]}, 128'b0);
      @(negedge clk);
      do_load(2'd2, PAT, 128, 1'b0, -1, 16'h0078, 0, 1'b0, mk(PAT, 1'b1, 1'b0));

`ifdef GAL_FUSE_SECURITY_EN
      drv_sec = 1'b1;
      do_load(2'd0, 128'h5A, 8, 1'b0, -1, 16'h005A, 0, 1'b0, mk(128'h5A, 1'b1, 1'b0));
      drv_sec   = 1'b0;
      sel       = 2'd0;
      drv_start = 1'b1;
      @(negedge clk);
      drv_start = 1'b0;
      @(negedge clk);
      check("locked busy", {127'b0, busy_v[0]}, 128'b0);
      check("locked table", {120'b0, t0}, 128'h5A);
      drv_rst = 1'b1;
      @(negedge clk);
      drv_rst = 1'b0;
      check("unlock reset table", {120'b0, t0}, 128'hFF);
      do_load(2'd0, 128'h33, 8, 1'b0, -1, 16'h0033, 0, 1'b0, mk(128'h33, 1'b1, 1'b0));
`endif

      repeat (2) @(negedge clk);
      check("d0 scoreboard drained", 128'(q0.size()), 128'b0);
      check("d1 scoreboard drained", 128'(q1.size()), 128'b0);
      check("d2 scoreboard drained", 128'(q2.size()), 128'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
